// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced button level into one-cycle press/release/repeat events,
// a long-press hold level and a running press count.
// Optional double-click detection is compiled in with `define DBL_CLICK_EN.
module button_event_decoder #(
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000,
   parameter int DBL_WINDOW    = 12500000,
   parameter int CNT_W         = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_valid,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       hold,
   output logic       repeat_pulse,
   output logic [7:0] press_count,
   output logic       dbl_pulse
);

   typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             btn_q;

`ifdef DBL_CLICK_EN
   localparam logic [CNT_W-1:0] DBL_LIM = CNT_W'(DBL_WINDOW);
   logic armed;
   logic last_dbl;   // previous press was a double click; its release must not re-arm
   logic dbl_q;
   logic dbl_hit;
   assign dbl_hit   = armed && (cnt < DBL_LIM);
   assign dbl_pulse = dbl_q;
`else
   assign dbl_pulse = 1'b0;
`endif

   // Single input register; the FSM only ever looks at btn_q.
   always_ff @(posedge clk) begin
      if (rst) btn_q <= 1'b0;
      else     btn_q <= btn_valid;
   end

   // Event FSM with registered outputs; release has priority over hold/repeat boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         hold          <= 1'b0;
         press_count   <= 8'd0;
`ifdef DBL_CLICK_EN
         armed         <= 1'b0;
         last_dbl      <= 1'b0;
         dbl_q         <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
`ifdef DBL_CLICK_EN
         dbl_q         <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (btn_q) begin
                  state       <= PRESS;
                  press_pulse <= 1'b1;
                  press_count <= press_count + 8'd1;
                  cnt         <= '0;
`ifdef DBL_CLICK_EN
                  dbl_q       <= dbl_hit;
                  last_dbl    <= dbl_hit;
                  armed       <= 1'b0;
`endif
               end else begin
`ifdef DBL_CLICK_EN
                  // Count time since release, saturating at the window edge.
                  if (cnt != DBL_LIM) cnt   <= cnt + CNT_ONE;
                  else                armed <= 1'b0;
`endif
               end
            end
            PRESS: begin
               if (!btn_q) begin
                  state         <= IDLE;
                  release_pulse <= 1'b1;
                  cnt           <= '0;
`ifdef DBL_CLICK_EN
                  armed         <= !last_dbl;
`endif
               end else if (cnt == HOLD_LAST) begin
                  state        <= HELD;
                  hold         <= 1'b1;
                  repeat_pulse <= 1'b1;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HELD: begin
               if (!btn_q) begin
                  state         <= IDLE;
                  hold          <= 1'b0;
                  release_pulse <= 1'b1;
                  cnt           <= '0;
`ifdef DBL_CLICK_EN
                  armed         <= !last_dbl;
`endif
               end else if (cnt == REP_LAST) begin
                  repeat_pulse <= 1'b1;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               hold  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (HOLD=10, REPEAT=4, DBL_WINDOW=20, CNT_W=8).
// Cycle c means "c rising edges after the stimulus change", sampled 1ns after the edge.
module tb_button_event_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_valid = 1'b0;
   logic       press_pulse, release_pulse, hold, repeat_pulse, dbl_pulse;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_count = 8'd0;

   button_event_decoder #(
      .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .DBL_WINDOW(20), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .btn_valid(btn_valid),
      .press_pulse(press_pulse), .release_pulse(release_pulse), .hold(hold),
      .repeat_pulse(repeat_pulse), .press_count(press_count), .dbl_pulse(dbl_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      btn_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // {press, release, repeat, hold, dbl}
   function automatic logic [4:0] outs();
      return {press_pulse, release_pulse, repeat_pulse, hold, dbl_pulse};
   endfunction

   task automatic test_reset();
      logic [4:0] e;
      rst = 1'b1;
      btn_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (outs() !== 5'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got %b cnt %0d exp 00000 cnt 0", i, outs(), press_count);
         end
      end
      rst = 1'b0;
      exp_count = 8'd0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 3) btn_valid = 1'b0;
         e = {c == 2, c == 5, 1'b0, 1'b0, 1'b0};
         checks++;
         if (outs() !== e) begin
            errors++;
            $display("FAIL reset_release cyc %0d got %b exp %b", c, outs(), e);
         end
      end
      exp_count = 8'd1;
      checks++;
      if (press_count !== exp_count) begin
         errors++;
         $display("FAIL reset_count got %0d exp %0d", press_count, exp_count);
      end
   endtask

   task automatic test_short_press();
      logic [4:0] e;
      idle(30);
      btn_valid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 5) btn_valid = 1'b0;
         e = {c == 2, c == 7, 1'b0, 1'b0, 1'b0};
         checks++;
         if (outs() !== e) begin
            errors++;
            $display("FAIL short_press cyc %0d got %b exp %b", c, outs(), e);
         end
      end
      exp_count = exp_count + 8'd1;
      checks++;
      if (press_count !== exp_count) begin
         errors++;
         $display("FAIL short_count got %0d exp %0d", press_count, exp_count);
      end
   endtask

   task automatic test_long_hold();
      logic [4:0] e;
      logic       rp;
      idle(30);
      btn_valid = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (c == 30) btn_valid = 1'b0;
         rp = (c == 12) || (c == 16) || (c == 20) || (c == 24) || (c == 28);
         e = {c == 2, c == 32, rp, (c >= 12) && (c <= 31), 1'b0};
         checks++;
         if (outs() !== e) begin
            errors++;
            $display("FAIL long_hold cyc %0d got %b exp %b", c, outs(), e);
         end
      end
      exp_count = exp_count + 8'd1;
   endtask

   task automatic test_release_on_repeat();
      logic [4:0] e;
      idle(30);
      btn_valid = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (c == 18) btn_valid = 1'b0;
         e = {c == 2, c == 20, (c == 12) || (c == 16), (c >= 12) && (c <= 19), 1'b0};
         checks++;
         if (outs() !== e) begin
            errors++;
            $display("FAIL release_on_repeat cyc %0d got %b exp %b", c, outs(), e);
         end
      end
      exp_count = exp_count + 8'd1;
   endtask

   task automatic test_count_wrap();
      int np = 0;
      int nr = 0;
      int nx = 0;
      idle(30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (press_count !== 8'd0) begin
         errors++;
         $display("FAIL wrap_reset got %0d exp 0", press_count);
      end
      for (int p = 0; p < 256; p++) begin
         for (int k = 0; k < 4; k++) begin
            btn_valid = (k == 0);
            tick();
            np += int'(press_pulse);
            nr += int'(release_pulse);
            nx += int'(repeat_pulse) + int'(hold);
         end
         if (p == 254) begin
            // Pulse 254's press lands 2 edges after its rise; 255 presses seen by now.
            checks++;
            if (press_count !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255 got %0d exp 255", press_count);
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         np += int'(press_pulse);
         nr += int'(release_pulse);
      end
      checks++;
      if (press_count !== 8'd0) begin
         errors++;
         $display("FAIL wrap_count got %0d exp 0", press_count);
      end
      checks++;
      if (np !== 256 || nr !== 256 || nx !== 0) begin
         errors++;
         $display("FAIL wrap_pulses press %0d rel %0d hold/rep %0d exp 256 256 0", np, nr, nx);
      end
   endtask

`ifdef DBL_CLICK_EN
   task automatic test_dbl_click();
      logic [1:0] e;
      idle(30);
      // Three quick taps: second is a double click, third must not re-trigger.
      btn_valid = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         btn_valid = (c == 5) || (c == 10);
         e = {(c == 2) || (c == 7) || (c == 12), c == 7};
         checks++;
         if ({press_pulse, dbl_pulse} !== e) begin
            errors++;
            $display("FAIL dbl_quick cyc %0d got %b exp %b", c, {press_pulse, dbl_pulse}, e);
         end
      end
      idle(30);
      // Second press 27 edges after release: outside the window.
      btn_valid = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         tick();
         btn_valid = (c == 28);
         e = {(c == 2) || (c == 30), 1'b0};
         checks++;
         if ({press_pulse, dbl_pulse} !== e) begin
            errors++;
            $display("FAIL dbl_gap cyc %0d got %b exp %b", c, {press_pulse, dbl_pulse}, e);
         end
      end
      exp_count = exp_count + 8'd5;
   endtask
`else
   task automatic test_dbl_off();
      idle(30);
      btn_valid = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         btn_valid = (c == 5);
         checks++;
         if (dbl_pulse !== 1'b0 || press_pulse !== ((c == 2) || (c == 7))) begin
            errors++;
            $display("FAIL dbl_off cyc %0d got dbl %b press %b", c, dbl_pulse, press_pulse);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_short_press();
      test_long_hold();
      test_release_on_repeat();
      checks++;
      if (press_count !== exp_count) begin
         errors++;
         $display("FAIL running_count got %0d exp %0d", press_count, exp_count);
      end
`ifdef DBL_CLICK_EN
      test_dbl_click();
`else
      test_dbl_off();
`endif
      test_count_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
